mp1000_cart_loader: RTL and testbench

MP1000_CART_LOADER -- requirements
Module: mp1000_cart_loader

---
 rtl/mp1000_cart_loader_if.sv | 26 ++
 rtl/mp1000_cart_loader.sv | 145 ++++++++++++++
 tb/tb_mp1000_cart_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mp1000_cart_loader_if.sv
// Download-port and cartridge-RAM write bus for the MP1000 cartridge loader.
// The master side is the loader: it consumes ioctl bytes and drives RAM writes.
interface mp1000_cart_loader_if #(
  parameter int MAX_AW = 14
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              rom_req;
  logic              rom_ack;
  logic [MAX_AW-1:0] rom_addr;
  logic [7:0]        rom_data;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
    output ioctl_wait, rom_req, rom_addr, rom_data
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_ack,
    input  ioctl_wait, rom_req, rom_addr, rom_data
  );
endinterface

// File: rtl/mp1000_cart_loader.sv
// MP1000 cartridge loader: takes a byte-serial ioctl download, queues bytes in a
// 2-entry FIFO towards cartridge RAM, tracks the highest written address to
// derive the CPU mirror mask, and holds the CPU in reset while loading.
module mp1000_cart_loader #(
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter int         MAX_AW     = 14
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  mp1000_cart_loader_if.master bus,
  output logic [MAX_AW-1:0]   cart_mask,
  output logic                cart_loaded,
  output logic                load_error,
  output logic                cpu_reset_hold
);

  localparam int ENTRY_W = MAX_AW + 8;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         fifo_count, fifo_count_d;
  logic [ENTRY_W-1:0] slot0, slot1, slot0_d, slot1_d;
  logic [ENTRY_W-1:0] new_entry;
  logic [MAX_AW-1:0]  max_addr;
  logic [MAX_AW-1:0]  wr_addr;
  logic               seen_byte;
  logic               in_range, has_space, push, pop, wr_drop;
  logic               enter_load, latch_mask, finish_load;

  // Smallest all-ones mask covering addr, never below 2 KiB of mirroring.
  function automatic logic [MAX_AW-1:0] mirror_mask(input logic [MAX_AW-1:0] addr);
    logic [MAX_AW-1:0] m;
    m = addr;
    for (int i = 1; i < MAX_AW; i++) m = m | (addr >> i);
    return m | MAX_AW'(11'h7FF);
  endfunction

  assign wr_addr        = bus.ioctl_addr[MAX_AW-1:0];
  assign new_entry      = {wr_addr, bus.ioctl_dout};
  assign in_range       = (bus.ioctl_addr >> MAX_AW) == 25'd0;
  assign pop            = (fifo_count != 2'd0) && bus.rom_ack;
  assign has_space      = (fifo_count != 2'd2) || pop;
  assign push           = (state_q == LOAD) && bus.ioctl_wr && in_range && has_space;
  assign wr_drop        = (state_q == LOAD) && bus.ioctl_wr && (!in_range || !has_space);

  assign bus.rom_req    = fifo_count != 2'd0;
  assign bus.ioctl_wait = fifo_count == 2'd2;
  assign bus.rom_addr   = slot0[ENTRY_W-1:8];
  assign bus.rom_data   = slot0[7:0];

  // Next-state decode and one-cycle control strobes for the load sequence.
  always_comb begin
    state_d     = state_q;
    enter_load  = 1'b0;
    latch_mask  = 1'b0;
    finish_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ioctl_download && (bus.ioctl_index == CART_INDEX)) begin
          state_d    = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        if (!bus.ioctl_download) state_d = FLUSH;
      end
      FLUSH: begin
        if (fifo_count == 2'd0) begin
          state_d    = DONE;
          latch_mask = 1'b1;
        end
      end
      DONE: begin
        finish_load = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO next contents: pop shifts the tail to the head, push lands behind what remains.
  always_comb begin
    slot0_d      = slot0;
    slot1_d      = slot1;
    fifo_count_d = fifo_count;
    if (pop) slot0_d = slot1;
    if (push) begin
      if ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)) slot0_d = new_entry;
      else                                                         slot1_d = new_entry;
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count + 2'd1;
      2'b01:   fifo_count_d = fifo_count - 2'd1;
      default: fifo_count_d = fifo_count;
    endcase
  end

  // State and FIFO occupancy; reset drops any queued entries.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fifo_count <= 2'd0;
    end else begin
      state_q    <= state_d;
      fifo_count <= fifo_count_d;
    end
  end

  // FIFO payload storage; validity is carried entirely by fifo_count.
  always_ff @(posedge clk_sys) begin
    slot0 <= slot0_d;
    slot1 <= slot1_d;
  end

  // Image bookkeeping and status outputs, persisting across IDLE.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      max_addr       <= '0;
      seen_byte      <= 1'b0;
      cart_mask      <= '0;
      cart_loaded    <= 1'b0;
      load_error     <= 1'b0;
      cpu_reset_hold <= 1'b0;
    end else if (enter_load) begin
      max_addr       <= '0;
      seen_byte      <= 1'b0;
      cart_loaded    <= 1'b0;
      load_error     <= 1'b0;
      cpu_reset_hold <= 1'b1;
    end else begin
      if (push) begin
        seen_byte <= 1'b1;
        if (wr_addr > max_addr) max_addr <= wr_addr;
      end
      if (wr_drop) load_error <= 1'b1;
      if (latch_mask) cart_mask <= seen_byte ? mirror_mask(max_addr) : '0;
      if (finish_load) begin
        cart_loaded    <= seen_byte && !load_error;
        cpu_reset_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mp1000_cart_loader.sv
// Scoreboard bench for mp1000_cart_loader: the driver predicts RAM writes and
// final status from the download contents; a monitor checks every RAM write.
module tb_mp1000_cart_loader;
  localparam int         MAX_AW     = 14;
  localparam logic [7:0] CART_INDEX = 8'd1;

  logic              clk_sys = 1'b0;
  logic              reset_n = 1'b0;
  logic [MAX_AW-1:0] cart_mask;
  logic              cart_loaded, load_error, cpu_reset_hold;

  mp1000_cart_loader_if #(.MAX_AW(MAX_AW)) bus ();

  mp1000_cart_loader #(.CART_INDEX(CART_INDEX), .MAX_AW(MAX_AW)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .bus            (bus.master),
    .cart_mask      (cart_mask),
    .cart_loaded    (cart_loaded),
    .load_error     (load_error),
    .cpu_reset_hold (cpu_reset_hold)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad   = 0;
  int writes = 0;
  int ack_mode = 0;  // 0: ack tied high, 1: random ack, 2: ack held low

  logic [MAX_AW+7:0] exp_q[$];
  logic [24:0]       img_addr[$];
  logic [7:0]        img_data[$];

  int unsigned exp_mask   = 0;
  bit          exp_loaded = 0;
  bit          exp_error  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int unsigned model_mask(input int unsigned mx);
    int unsigned m;
    m = 'h7FF;
    while (m < mx) m = m * 2 + 1;
    return m;
  endfunction

  task automatic check_status(input string tag);
    check({tag, "_cart_mask"},   32'(cart_mask),   exp_mask);
    check({tag, "_cart_loaded"}, 32'(cart_loaded), 32'(exp_loaded));
    check({tag, "_load_error"},  32'(load_error),  32'(exp_error));
  endtask

  task automatic wait_hold_low(input string tag);
    int cyc;
    cyc = 0;
    while (cpu_reset_hold && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (cyc >= 3000) fail_now({tag, "_done_timeout"});
  endtask

  // Drive the image in img_addr/img_data, obeying ioctl_wait, and predict the result.
  task automatic run_load(input string tag, input logic [7:0] idx, input int max_gap);
    bit          seen, err, first;
    int unsigned mx;
    int          cyc;
    bit          match;
    seen  = 0;
    err   = 0;
    first = 1;
    mx    = 0;
    match = (idx == CART_INDEX);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick();
    if (match) check({tag, "_hold_at_entry"}, 32'(cpu_reset_hold), 32'd1);
    for (int i = 0; i < img_addr.size(); i++) begin
      cyc = 0;
      while (bus.ioctl_wait && cyc < 1000) begin
        tick();
        cyc++;
      end
      if (cyc >= 1000) fail_now({tag, "_wait_timeout"});
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = img_addr[i];
      bus.ioctl_dout = img_data[i];
      if (match) begin
        if (img_addr[i] < 25'(2 ** MAX_AW)) begin
          exp_q.push_back({img_addr[i][MAX_AW-1:0], img_data[i]});
          seen = 1;
          if (int'(img_addr[i]) > mx) mx = img_addr[i];
        end else begin
          err = 1;
        end
      end
      tick();
      bus.ioctl_wr = 1'b0;
      if (match && first && img_addr[i] < 25'(2 ** MAX_AW)) begin
        check({tag, "_latency_rom_req"}, 32'(bus.rom_req), 32'd1);
        first = 0;
      end
      repeat ($urandom_range(0, max_gap)) tick();
    end
    if (match) check({tag, "_hold_before_end"}, 32'(cpu_reset_hold), 32'd1);
    bus.ioctl_download = 1'b0;
    if (match) begin
      wait_hold_low(tag);
      exp_mask   = seen ? model_mask(mx) : 0;
      exp_loaded = seen && !err;
      exp_error  = err;
      check({tag, "_queue_drained"}, exp_q.size(), 0);
    end else begin
      repeat (6) tick();
    end
  endtask

  // Acknowledge driver for the cartridge RAM side.
  initial begin
    bus.rom_ack = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      case (ack_mode)
        0:       bus.rom_ack = 1'b1;
        1:       bus.rom_ack = 1'($urandom_range(0, 1));
        default: bus.rom_ack = 1'b0;
      endcase
    end
  end

  // Monitor: every accepted RAM write must match the oldest predicted entry.
  initial begin
    logic [MAX_AW+7:0] e;
    forever begin
      @(negedge clk_sys);
      if (reset_n && bus.rom_req && bus.rom_ack) begin
        writes++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%0h required=none", {bus.rom_addr, bus.rom_data});
        end else begin
          e = exp_q.pop_front();
          check("rom_write", 32'({bus.rom_addr, bus.rom_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int unsigned hi;
    int n;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 8'd0;

    // Reset state
    #1;
    check("rst_rom_req",        32'(bus.rom_req),     0);
    check("rst_ioctl_wait",     32'(bus.ioctl_wait),  0);
    check("rst_cart_mask",      32'(cart_mask),       0);
    check("rst_cart_loaded",    32'(cart_loaded),     0);
    check("rst_load_error",     32'(load_error),      0);
    check("rst_cpu_reset_hold", 32'(cpu_reset_hold),  0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // 4 KiB image, ack tied high, back-to-back bytes
    ack_mode = 0;
    img_addr.delete();
    img_data.delete();
    for (int i = 0; i < 4096; i++) begin
      img_addr.push_back(25'(i));
      img_data.push_back(8'($urandom));
    end
    w0 = writes;
    run_load("img4k", CART_INDEX, 0);
    check("img4k_write_count", writes - w0, 4096);
    check_status("img4k");
    check("img4k_mask_value", 32'(cart_mask), 32'hFFF);
    check("img4k_hold_released", 32'(cpu_reset_hold), 0);

    // Non-matching index: nothing changes
    ack_mode = 1;
    img_addr.delete();
    img_data.delete();
    for (int i = 0; i < 5; i++) begin
      img_addr.push_back(25'(i));
      img_data.push_back(8'($urandom));
    end
    run_load("idx0", 8'd0, 1);
    check_status("idx0");
    check("idx0_hold", 32'(cpu_reset_hold), 0);
    check("idx0_rom_req", 32'(bus.rom_req), 0);

    // 100-byte image, random ack
    img_addr.delete();
    img_data.delete();
    for (int i = 0; i < 100; i++) begin
      img_addr.push_back(25'(i));
      img_data.push_back(8'($urandom));
    end
    run_load("img100", CART_INDEX, 2);
    check_status("img100");
    check("img100_mask_value", 32'(cart_mask), 32'h7FF);

    // Zero-byte matching download
    img_addr.delete();
    img_data.delete();
    run_load("empty", CART_INDEX, 0);
    check_status("empty");

    // Out-of-range address only
    img_addr.delete();
    img_data.delete();
    img_addr.push_back(25'h4000);
    img_data.push_back(8'hA5);
    w0 = writes;
    run_load("oob", CART_INDEX, 0);
    check("oob_no_write", writes - w0, 0);
    check_status("oob");

    // Back-pressure: ack held low, three back-to-back writes
    ack_mode = 2;
    tick();
    tick();
    w0 = writes;
    bus.ioctl_index    = CART_INDEX;
    bus.ioctl_download = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(k);
      bus.ioctl_dout = 8'($urandom);
      if (k < 2) exp_q.push_back({MAX_AW'(k), bus.ioctl_dout});
      tick();
      if (k == 1) check("bp_wait_after_two", 32'(bus.ioctl_wait), 1);
    end
    bus.ioctl_wr = 1'b0;
    check("bp_overflow_error", 32'(load_error), 1);
    repeat (6) tick();
    check("bp_head_stable_req",  32'(bus.rom_req), 1);
    check("bp_head_stable_addr", 32'(bus.rom_addr), 0);
    ack_mode = 0;
    bus.ioctl_download = 1'b0;
    wait_hold_low("bp");
    check("bp_write_count", writes - w0, 2);
    exp_mask   = 'h7FF;
    exp_loaded = 0;
    exp_error  = 1;
    check_status("bp");

    // Randomized images with random ack and occasional out-of-range bytes
    ack_mode = 1;
    for (int t = 0; t < 6; t++) begin
      img_addr.delete();
      img_data.delete();
      n = $urandom_range(1, 200);
      case ($urandom_range(0, 3))
        0:       hi = 'h3FF;
        1:       hi = 'hFFF;
        2:       hi = 'h3FFF;
        default: hi = 'h40FF;
      endcase
      for (int i = 0; i < n; i++) begin
        img_addr.push_back(25'($urandom_range(0, hi)));
        img_data.push_back(8'($urandom));
      end
      run_load("rand", CART_INDEX, 3);
      check_status("rand");
    end

    // Reset mid-load with two entries queued, download left high
    ack_mode = 2;
    tick();
    tick();
    w0 = writes;
    bus.ioctl_index    = CART_INDEX;
    bus.ioctl_download = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(16 + k);
      bus.ioctl_dout = 8'($urandom);
      exp_q.push_back({MAX_AW'(16 + k), bus.ioctl_dout});
      tick();
    end
    bus.ioctl_wr = 1'b0;
    check("rst_mid_full", 32'(bus.ioctl_wait), 1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_rom_req", 32'(bus.rom_req), 0);
    check("rst_mid_hold",    32'(cpu_reset_hold), 0);
    check("rst_mid_wait",    32'(bus.ioctl_wait), 0);
    exp_mask   = 0;
    exp_loaded = 0;
    exp_error  = 0;
    check_status("rst_mid");
    ack_mode = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_restart_hold",    32'(cpu_reset_hold), 1);
    check("rst_restart_rom_req", 32'(bus.rom_req), 0);
    bus.ioctl_download = 1'b0;
    wait_hold_low("rst_restart");
    repeat (3) tick();
    check("rst_no_writes", writes - w0, 0);
    check_status("rst_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
